// File: rtl/drivetrain_pkg.sv
// Shared definitions for the drive-train protection path.
// Provides the overcurrent channel state type, channel index constants,
// default timing constants (100 MHz clock) and a counter-width helper.
package drivetrain_pkg;

  typedef enum logic [2:0] {
    OFF,
    BLANK,
    ARMED,
    TRIP,
    HOLDOFF
  } oc_state_t;

  localparam int unsigned LEFT  = 0;
  localparam int unsigned RIGHT = 1;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_BLANK_CYCLES    = 100;   // 1 us
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50;    // 500 ns
  localparam int unsigned DEF_HOLDOFF_CYCLES  = 1000;  // 10 us
  localparam int unsigned DEF_CNT_W           = 8;

  // Width of a counter that must reach (largest count - 1).
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/oc_channel.sv
// One overcurrent qualification channel.
// Synchronises the async comparator, blanks after each PWM turn-on,
// debounces, emits a single-cycle trip pulse, then holds off.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   sense_raw    - async comparator output, high = overcurrent
//   pwm          - gate-drive PWM (clk domain), high = conducting
//   sns_disable  - one-cycle trip pulse
//   armed        - channel is qualifying sense
//   trip_count   - saturating trip counter
module oc_channel
  import drivetrain_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned BLANK_CYCLES    = DEF_BLANK_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense_raw,
  input  logic             pwm,
  output logic             sns_disable,
  output logic             armed,
  output logic [CNT_W-1:0] trip_count
);

  localparam int unsigned TW = timer_width(BLANK_CYCLES, DEBOUNCE_CYCLES, HOLDOFF_CYCLES);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DEB_LAST   = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLDOFF_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   pwm_q;
  logic                   pwm_rise;
  oc_state_t              state, state_next;
  logic [TW-1:0]          timer, timer_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sense_raw};
      pwm_q  <= pwm;
    end
  end

  assign s_sync   = sync_q[SYNC_STAGES-1];
  assign pwm_rise = pwm & ~pwm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // BLANK, ARMED and HOLDOFF are mutually exclusive, so one timer serves as
  // blank counter, qualify counter and hold-off counter in turn.
  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      OFF: begin
        if (pwm_rise) begin
          state_next = BLANK;
          timer_next = '0;
        end
      end
      BLANK: begin
        if (!pwm) begin
          state_next = OFF;
        end else if (timer == BLANK_LAST) begin
          state_next = ARMED;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      ARMED: begin
        if (!pwm) begin
          state_next = OFF;
          timer_next = '0;
        end else if (s_sync) begin
          if (timer == DEB_LAST) state_next = TRIP;
          else                   timer_next = timer + TW'(1);
        end else begin
          timer_next = '0;
        end
      end
      TRIP: begin
        state_next = HOLDOFF;
        timer_next = '0;
      end
      HOLDOFF: begin
        if (timer == HOLD_LAST) begin
          state_next = pwm ? BLANK : OFF;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: begin
        state_next = OFF;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trip_count <= '0;
    end else if (state == TRIP && trip_count != '1) begin
      trip_count <= trip_count + CNT_W'(1);
    end
  end

  assign sns_disable = (state == TRIP);
  assign armed       = (state == ARMED);

endmodule

// File: rtl/overcurrent_detector.sv
// Overcurrent detector for the left/right H-bridges; feeds the disable
// handler's SnsDisable input with qualified one-cycle trip pulses.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   sense_raw[1:0] - async comparators, [0]=left, [1]=right
//   pwm[1:0]       - gate-drive PWM per channel (clk domain)
//   sns_disable    - per-channel trip pulse
//   armed          - per-channel ARMED status
//   trip_count0/1  - saturating trip counters, left/right
module overcurrent_detector
  import drivetrain_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned BLANK_CYCLES    = DEF_BLANK_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sense_raw,
  input  logic [1:0]       pwm,
  output logic [1:0]       sns_disable,
  output logic [1:0]       armed,
  output logic [CNT_W-1:0] trip_count0,
  output logic [CNT_W-1:0] trip_count1
);

  oc_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .clk        (clk),
    .rst        (rst),
    .sense_raw  (sense_raw[LEFT]),
    .pwm        (pwm[LEFT]),
    .sns_disable(sns_disable[LEFT]),
    .armed      (armed[LEFT]),
    .trip_count (trip_count0)
  );

  oc_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .clk        (clk),
    .rst        (rst),
    .sense_raw  (sense_raw[RIGHT]),
    .pwm        (pwm[RIGHT]),
    .sns_disable(sns_disable[RIGHT]),
    .armed      (armed[RIGHT]),
    .trip_count (trip_count1)
  );

endmodule

// File: tb/tb_overcurrent_detector.sv
module tb_overcurrent_detector;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned BLANK = 10;
  localparam int unsigned DEB   = 5;
  localparam int unsigned HOLD  = 20;
  localparam int unsigned CW    = 8;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    sense_raw;
  logic [1:0]    pwm;
  logic [1:0]    sns_disable;
  logic [1:0]    armed;
  logic [CW-1:0] trip_count0;
  logic [CW-1:0] trip_count1;

  always #5 clk = ~clk;

  overcurrent_detector #(
    .SYNC_STAGES    (SYNC),
    .BLANK_CYCLES   (BLANK),
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES (HOLD),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sense_raw  (sense_raw),
    .pwm        (pwm),
    .sns_disable(sns_disable),
    .armed      (armed),
    .trip_count0(trip_count0),
    .trip_count1(trip_count1)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: time-stamped windows over an absolute cycle index.
  localparam int P_OFF = 0, P_BLANK = 1, P_ARM = 2, P_TRIP = 3, P_HOLD = 4;
  int         m_phase[2];
  longint     m_blank_end[2];
  longint     m_hold_end[2];
  int         m_run[2];
  int         m_cnt[2];
  bit         m_prev[2];
  logic [1:0] hist[$];
  longint     cyc = 0;

  task automatic model_adv(input bit r, input logic [1:0] p, input logic [1:0] s);
    logic [1:0] ss;
    ss = hist[0];
    for (int i = 0; i < 2; i++) begin
      bit rise;
      rise = p[i] && !m_prev[i];
      if (r) begin
        m_phase[i] = P_OFF;
        m_cnt[i]   = 0;
        m_prev[i]  = 1'b0;
      end else begin
        m_prev[i] = p[i];
        case (m_phase[i])
          P_OFF: if (rise) begin
            m_phase[i]     = P_BLANK;
            m_blank_end[i] = cyc + BLANK;
          end
          P_BLANK: begin
            if (!p[i]) m_phase[i] = P_OFF;
            else if (cyc == m_blank_end[i]) begin
              m_phase[i] = P_ARM;
              m_run[i]   = 0;
            end
          end
          P_ARM: begin
            if (!p[i]) m_phase[i] = P_OFF;
            else if (ss[i]) begin
              m_run[i]++;
              if (m_run[i] == DEB) m_phase[i] = P_TRIP;
            end else m_run[i] = 0;
          end
          P_TRIP: begin
            if (m_cnt[i] < CMAX) m_cnt[i]++;
            m_hold_end[i] = cyc + HOLD;
            m_phase[i]    = P_HOLD;
          end
          default: if (cyc == m_hold_end[i]) begin
            m_phase[i]     = p[i] ? P_BLANK : P_OFF;
            m_blank_end[i] = cyc + BLANK;
          end
        endcase
      end
    end
    if (r) begin
      hist.delete();
      for (int k = 0; k < int'(SYNC); k++) hist.push_back(2'b00);
    end else begin
      void'(hist.pop_front());
      hist.push_back(s);
    end
    cyc++;
  endtask

  task automatic model_check();
    chk("model_sns_disable", int'(sns_disable),
        int'({m_phase[1] == P_TRIP, m_phase[0] == P_TRIP}));
    chk("model_armed", int'(armed), int'({m_phase[1] == P_ARM, m_phase[0] == P_ARM}));
    chk("model_trip_count0", int'(trip_count0), m_cnt[0]);
    chk("model_trip_count1", int'(trip_count1), m_cnt[1]);
  endtask

  task automatic tick(input bit r, input logic [1:0] p, input logic [1:0] s);
    rst = r; pwm = p; sense_raw = s;
    model_adv(r, p, s);
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic dchk(input string name, input logic [1:0] dis, input logic [1:0] arm,
                      input int c0, input int c1);
    chk({name, "_sns_disable"}, int'(sns_disable), int'(dis));
    chk({name, "_armed"}, int'(armed), int'(arm));
    chk({name, "_trip_count0"}, int'(trip_count0), c0);
    chk({name, "_trip_count1"}, int'(trip_count1), c1);
  endtask

  typedef struct {
    bit         r;
    logic [1:0] p;
    logic [1:0] s;
    int         reps;
    logic [1:0] dis;
    logic [1:0] arm;
    int         c0;
    int         c1;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rp, rs;
    bit         found;
    int         hits;

    for (int i = 0; i < 2; i++) begin
      m_phase[i] = P_OFF; m_cnt[i] = 0; m_prev[i] = 1'b0; m_run[i] = 0;
      m_blank_end[i] = 0; m_hold_end[i] = 0;
    end
    for (int k = 0; k < int'(SYNC); k++) hist.push_back(2'b00);
    rst = 1'b1; pwm = 2'b00; sense_raw = 2'b00;

    // Reset, blanking after release, basic trip on channel 0 (cycle t = row 3 first tick).
    tbl[0] = '{1'b1, 2'b11, 2'b11, 5,  2'b00, 2'b00, 0, 0};
    tbl[1] = '{1'b0, 2'b11, 2'b00, 10, 2'b00, 2'b00, 0, 0};
    tbl[2] = '{1'b0, 2'b11, 2'b00, 1,  2'b00, 2'b11, 0, 0};
    tbl[3] = '{1'b0, 2'b11, 2'b01, 6,  2'b00, 2'b11, 0, 0};
    tbl[4] = '{1'b0, 2'b11, 2'b01, 1,  2'b01, 2'b10, 0, 0};
    tbl[5] = '{1'b0, 2'b11, 2'b01, 1,  2'b00, 2'b10, 1, 0};
    tbl[6] = '{1'b0, 2'b11, 2'b00, 19, 2'b00, 2'b10, 1, 0};
    tbl[7] = '{1'b0, 2'b11, 2'b00, 1,  2'b00, 2'b10, 1, 0};
    tbl[8] = '{1'b0, 2'b11, 2'b00, 10, 2'b00, 2'b11, 1, 0};

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < tbl[v].reps; k++) begin
        tick(tbl[v].r, tbl[v].p, tbl[v].s);
        if (tbl[v].r) dchk("reset_hold", 2'b00, 2'b00, 0, 0);
      end
      dchk($sformatf("vec%0d", v), tbl[v].dis, tbl[v].arm, tbl[v].c0, tbl[v].c1);
    end

    // Glitch rejection: DEB-1 high, 1 low, DEB-1 high.
    for (int k = 0; k < 17; k++) begin
      rs = (k < 4 || (k >= 5 && k < 9)) ? 2'b01 : 2'b00;
      tick(1'b0, 2'b11, rs);
      chk("glitch_sns_disable", int'(sns_disable), 0);
    end
    dchk("glitch_end", 2'b00, 2'b11, 1, 0);

    // Blanking on channel 1: pwm rises with sense already high.
    tick(1'b0, 2'b01, 2'b00);
    for (int k = 0; k < 4; k++) tick(1'b0, 2'b01, 2'b10);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 2'b11, 2'b10);
      if (k < 16) chk("blank_no_pulse", int'(sns_disable), 0);
      if (k == 10) chk("blank_last_armed1", int'(armed[1]), 0);
      if (k == 11) chk("blank_first_armed1", int'(armed[1]), 1);
    end
    chk("blank_trip_pulse", int'(sns_disable), 2);
    tick(1'b0, 2'b11, 2'b10);
    chk("blank_trip_count1", int'(trip_count1), 1);
    for (int k = 0; k < int'(HOLD) + 2; k++) tick(1'b0, 2'b01, 2'b10);
    for (int k = 0; k < 5; k++) tick(1'b0, 2'b11, 2'b10);
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 2'b01, 2'b10);
      chk("pwm_drop_no_pulse", int'(sns_disable[1]), 0);
      chk("pwm_drop_not_armed", int'(armed[1]), 0);
    end
    chk("pwm_drop_trip_count1", int'(trip_count1), 1);

    // Simultaneous trip.
    tick(1'b1, 2'b00, 2'b00);
    for (int k = 0; k < 11; k++) tick(1'b0, 2'b11, 2'b00);
    chk("simul_armed", int'(armed), 3);
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 2'b11, 2'b11);
      chk("simul_pulse", int'(sns_disable), (k == 7) ? 3 : 0);
    end

    // Saturation: continuous sense gives a trip every HOLD+BLANK+DEB+1 cycles.
    hits = 0;
    for (int k = 0; k < 260 * int'(HOLD + BLANK + DEB + 1); k++) begin
      tick(1'b0, 2'b11, 2'b11);
      if (sns_disable[0]) hits++;
    end
    chk("sat_pulses", hits, 260);
    chk("sat_trip_count0", int'(trip_count0), CMAX);
    chk("sat_trip_count1", int'(trip_count1), CMAX);

    // Reset in the TRIP cycle.
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick(1'b0, 2'b11, 2'b11);
      if (sns_disable[0]) found = 1'b1;
    end
    chk("trip_wait_found", int'(found), 1);
    tick(1'b1, 2'b11, 2'b11);
    dchk("rst_in_trip", 2'b00, 2'b00, 0, 0);
    tick(1'b0, 2'b11, 2'b11);
    dchk("rst_in_trip_after", 2'b00, 2'b00, 0, 0);

    // Randomised traffic against the reference model.
    rp = 2'b11; rs = 2'b00;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 49) == 0) rp[i] = ~rp[i];
        if ($urandom_range(0, 5) == 0)  rs[i] = ~rs[i];
      end
      tick($urandom_range(0, 1999) == 0, rp, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
